// File: rtl/bit_demux_collector32.sv
// Serial-bit to 32-bit word collector: steers accepted bits into an addressed or
// sequential position and hands the assembled word off on a valid/ready port.
module bit_demux_collector32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_bit,
  input  logic [4:0]  sel,
  input  logic        mode,
  input  logic        flush,
  output logic [31:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [5:0]  bit_count
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [31:0] mask_q, mask_d;
  logic [4:0]  ptr_q, ptr_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        mode_q, mode_d;
  logic        accept;
  logic        mode_eff;

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    mask_d   = mask_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    accept   = 1'b0;
    mode_eff = mode_q;
    case (state_q)
      FILL: begin
        accept = in_valid;
        // An empty word takes the live mode and latches it for the rest of the word.
        if (cnt_q == 6'd0) begin
          mode_eff = mode;
          mode_d   = mode;
        end
        if (accept) begin
          if (mode_eff) begin
            word_d[ptr_q] = in_bit;
            mask_d[ptr_q] = 1'b1;
            ptr_d         = ptr_q + 5'd1;
            cnt_d         = cnt_q + 6'd1;
          end else begin
            word_d[sel] = in_bit;
            mask_d[sel] = 1'b1;
            if (!mask_q[sel]) begin
              cnt_d = cnt_q + 6'd1;
            end
          end
        end
        if ((cnt_d == 6'd32) || (flush && ((cnt_q != 6'd0) || accept))) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (word_ready) begin
          state_d = FILL;
          word_d  = 32'd0;
          mask_d  = 32'd0;
          ptr_d   = 5'd0;
          cnt_d   = 6'd0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      word_q  <= 32'd0;
      mask_q  <= 32'd0;
      ptr_q   <= 5'd0;
      cnt_q   <= 6'd0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      mask_q  <= mask_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign in_ready   = (state_q == FILL);
  assign word_valid = (state_q == HOLD);
  assign word_out   = word_q;
  assign bit_count  = cnt_q;

endmodule

// File: tb/tb_bit_demux_collector32.sv
// Directed bench for bit_demux_collector32 with a position-set model checked every cycle
// and literal expectations at the key points of each scenario.
module tb_bit_demux_collector32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_bit = 1'b0;
  logic [4:0]  sel = 5'd0;
  logic        mode = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic [5:0]  bit_count;

  int checks = 0;
  int errors = 0;

  bit_demux_collector32 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .sel       (sel),
    .mode      (mode),
    .flush     (flush),
    .word_out  (word_out),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .bit_count (bit_count)
  );

  always #5 clk = ~clk;

  // Model: the word is a set of written positions plus their values; the count is
  // the size of that set and the sequential target is the next unwritten index.
  logic [31:0] m_word = 32'd0;
  logic [31:0] m_mask = 32'd0;
  logic        m_mode = 1'b0;
  logic        m_hold = 1'b0;

  always @(posedge clk) begin
    int n;
    int pos;
    logic me;
    n = $countones(m_mask);
    if (rst) begin
      m_word = 32'd0; m_mask = 32'd0; m_mode = 1'b0; m_hold = 1'b0;
    end else if (!m_hold) begin
      me = (n == 0) ? mode : m_mode;
      if (n == 0) m_mode = mode;
      if (in_valid) begin
        pos = me ? n : int'(sel);
        m_word[pos] = in_bit;
        m_mask[pos] = 1'b1;
      end
      if (($countones(m_mask) == 32) || (flush && ((n > 0) || in_valid))) m_hold = 1'b1;
    end else if (word_ready) begin
      m_word = 32'd0; m_mask = 32'd0; m_hold = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("mdl_in_ready", {31'd0, in_ready}, {31'd0, !m_hold});
    chk("mdl_word_valid", {31'd0, word_valid}, {31'd0, m_hold});
    chk("mdl_word_out", word_out, m_word);
    chk("mdl_bit_count", {26'd0, bit_count}, 32'($countones(m_mask)));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic b, input logic [4:0] s, input logic m, input logic f);
    in_valid = 1'b1; in_bit = b; sel = s; mode = m; flush = f;
    cyc();
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic handoff();
    word_ready = 1'b1;
    cyc();
    word_ready = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_word_valid"}, {31'd0, word_valid}, 32'd0);
    chk({tag, "_word_out"}, word_out, 32'd0);
    chk({tag, "_bit_count"}, {26'd0, bit_count}, 32'd0);
  endtask

  initial begin
    logic [31:0] pat;
    pat = 32'hA5A5F00F;
    cyc(); cyc();
    rst = 1'b0;
    chk_reset_vals("reset");

    // Sequential fill
    for (int i = 0; i < 32; i++) push(pat[i], 5'(31 - i), 1'b1, 1'b0);
    chk("seq_valid", {31'd0, word_valid}, 32'd1);
    chk("seq_word", word_out, 32'hA5A5F00F);
    chk("seq_count", {26'd0, bit_count}, 32'd32);
    chk("seq_in_ready", {31'd0, in_ready}, 32'd0);
    handoff();
    chk("seq_ho_word", word_out, 32'd0);
    chk("seq_ho_ready", {31'd0, in_ready}, 32'd1);

    // Addressed fill with overwrite
    push(1'b1, 5'd5, 1'b0, 1'b0);
    push(1'b0, 5'd5, 1'b0, 1'b0);
    chk("ovw_count", {26'd0, bit_count}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      if (i != 5) push(1'b1, 5'(i), 1'b0, 1'b0);
      if (i == 30) chk("ovw_not_yet", {31'd0, word_valid}, 32'd0);
    end
    chk("ovw_valid", {31'd0, word_valid}, 32'd1);
    chk("ovw_word", word_out, 32'hFFFFFFDF);
    chk("ovw_count32", {26'd0, bit_count}, 32'd32);
    handoff();

    // Flush partial, then flush on empty word
    push(1'b1, 5'd31, 1'b0, 1'b0);
    push(1'b1, 5'd0, 1'b0, 1'b0);
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("fl_valid", {31'd0, word_valid}, 32'd1);
    chk("fl_word", word_out, 32'h80000001);
    chk("fl_count", {26'd0, bit_count}, 32'd2);
    handoff();
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("fl_empty_ready", {31'd0, in_ready}, 32'd1);
    chk("fl_empty_count", {26'd0, bit_count}, 32'd0);

    // Flush with same-cycle accept
    for (int i = 0; i < 3; i++) push(1'b1, 5'd20, 1'b1, 1'b0);
    push(1'b1, 5'd20, 1'b1, 1'b1);
    chk("fla_word", word_out, 32'h0000000F);
    chk("fla_count", {26'd0, bit_count}, 32'd4);

    // Back-pressure in HOLD
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_bit = i[0]; sel = 5'(i * 3); flush = i[1];
      cyc();
    end
    in_valid = 1'b0; flush = 1'b0;
    chk("bp_word", word_out, 32'h0000000F);
    chk("bp_count", {26'd0, bit_count}, 32'd4);
    handoff();

    // Mode change mid-word is ignored
    push(1'b1, 5'd3, 1'b0, 1'b0);
    push(1'b1, 5'd7, 1'b1, 1'b0);
    chk("mode_word", word_out, 32'h00000088);
    push(1'b1, 5'd7, 1'b1, 1'b1);
    chk("mode_flush_count", {26'd0, bit_count}, 32'd2);
    handoff();

    // Reset mid-word, then reset together with hand-off in HOLD
    for (int i = 0; i < 17; i++) push(1'b1, 5'd0, 1'b1, 1'b0);
    chk("mid_count", {26'd0, bit_count}, 32'd17);
    rst = 1'b1; in_valid = 1'b1; flush = 1'b1; cyc();
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0;
    chk_reset_vals("rst_mid");
    push(1'b1, 5'd9, 1'b1, 1'b0);
    chk("rst_mid_bit0", word_out, 32'h00000001);
    for (int i = 0; i < 31; i++) push(1'b0, 5'd0, 1'b1, 1'b0);
    chk("rst_hold_valid", {31'd0, word_valid}, 32'd1);
    chk("rst_hold_word", word_out, 32'h00000001);
    rst = 1'b1; word_ready = 1'b1; cyc();
    rst = 1'b0; word_ready = 1'b0;
    chk_reset_vals("rst_hold");
    push(1'b1, 5'd12, 1'b1, 1'b0);
    chk("rst_hold_next", word_out, 32'h00000001);
    chk("rst_hold_next_cnt", {26'd0, bit_count}, 32'd1);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
